// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths, constants and fetch-path types
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            kill;
    } trk_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf_fifo.sv
// rtl/fetch_buf_fifo.sv - synchronous FIFO with flush, head exposed from storage flops
module fetch_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push_valid && !full;
    assign do_pop    = pop && !empty;

    // Flush discards everything, including a same-cycle push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem requests, kill-tracked in-flight queue, output buffer
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    trk_entry_t      trk_q [MAX_OUTSTANDING];
    trk_entry_t      trk_d [MAX_OUTSTANDING];
    logic [TCW-1:0]  trk_cnt_q, trk_cnt_d;
    logic [TCW-1:0]  trk_cnt_mid;
    logic            trk_push;
    logic            trk_pop;

    logic [BCW-1:0]  buf_cnt;
    logic            buf_empty;
    logic            buf_push;
    fetch_pkt_t      buf_in;
    fetch_pkt_t      buf_head;

    // Credit: every issued request already owns a free output-buffer slot.
    assign imem_req  = !reset && !redirect_valid
                    && (trk_cnt_q < TCW'(MAX_OUTSTANDING))
                    && ((8'(trk_cnt_q) + 8'(buf_cnt)) < 8'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign trk_push  = imem_req && imem_gnt;
    assign trk_pop   = imem_rvalid && (trk_cnt_q != '0);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (trk_push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Tracking queue is a shift register with the oldest request in slot 0.
    always_comb begin
        trk_d       = trk_q;
        trk_cnt_mid = trk_cnt_q - TCW'(trk_pop);
        if (trk_pop) begin
            for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
                trk_d[i] = trk_q[i + 1];
            end
        end
        if (trk_push) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (TCW'(i) == trk_cnt_mid) begin
                    trk_d[i].pc   = pc_q;
                    trk_d[i].kill = 1'b0;
                end
            end
        end
        if (redirect_valid) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                trk_d[i].kill = 1'b1;
            end
        end
        trk_cnt_d = trk_cnt_mid + TCW'(trk_push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            trk_cnt_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            trk_cnt_q <= trk_cnt_d;
            trk_q     <= trk_d;
        end
    end

    assign buf_push     = trk_pop && !trk_q[0].kill && !redirect_valid;
    assign buf_in.pc    = trk_q[0].pc;
    assign buf_in.instr = imem_rdata;

    fetch_buf_fifo #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (BUF_DEPTH)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push_valid (buf_push),
        .push_data  (buf_in),
        .pop        (id_valid && id_ready),
        .head_data  (buf_head),
        .count      (buf_cnt),
        .empty      (buf_empty)
    );

    assign id_valid = !buf_empty;
    assign id_pc    = id_valid ? buf_head.pc    : '0;
    assign id_instr = id_valid ? buf_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;

    logic        req2;
    logic [63:0] addr2;
    logic        gnt2 = 1'b1;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        redir2 = 1'b0;
    logic [63:0] rpc2 = '0;
    logic        ready2 = 1'b1;
    logic        idv2;
    logic [63:0] idpc2;
    logic [31:0] idinstr2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_grants = 0;

    logic [63:0] mem_addr_q [$];
    int          mem_due_q  [$];
    logic [63:0] got_pc     [$];
    logic [31:0] got_instr  [$];
    logic [63:0] got2_pc    [$];
    logic [31:0] got2_instr [$];
    logic        g2;
    logic [63:0] g2addr;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_gnt       (gnt2),
        .imem_rvalid    (rvalid2),
        .imem_rdata     (rdata2),
        .redirect_valid (redir2),
        .redirect_pc    (rpc2),
        .id_ready       (ready2),
        .id_valid       (idv2),
        .id_pc          (idpc2),
        .id_instr       (idinstr2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Grants and decode pops are sampled mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_gnt) begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cyc + lat);
                n_grants++;
            end
            if (id_valid && id_ready) begin
                got_pc.push_back(id_pc);
                got_instr.push_back(id_instr);
            end
            if (idv2 && got2_pc.size() < 4) begin
                got2_pc.push_back(idpc2);
                got2_instr.push_back(idinstr2);
            end
        end
        g2     = !reset && req2;
        g2addr = addr2;
    end

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_rvalid = 1'b0;
            rvalid2     = g2 && !reset;
            rdata2      = g2addr[31:0];
            if (reset) begin
                mem_addr_q.delete();
                mem_due_q.delete();
            end else if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr_q[0][31:0];
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_addr_q.delete();
        mem_due_q.delete();
        got_pc.delete();
        got_instr.delete();
        n_grants = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_got(input int n, input string tag);
        int k = 0;
        while (got_pc.size() < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq(tag, 64'(got_pc.size() >= n), 64'd1);
    endtask

    initial begin
        int gcyc;
        int vcyc;
        int k;
        reset          = 1'b1;
        imem_gnt       = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req",      64'(imem_req),  64'd0);
        check_eq("rst_addr",     imem_addr,      64'h0);
        check_eq("rst_id_valid", 64'(id_valid),  64'd0);
        check_eq("rst_id_pc",    id_pc,          64'h0);
        check_eq("rst_id_instr", 64'(id_instr),  64'h13);
        check_eq("rst2_addr",    addr2,          64'hFFFF_FFFF_FFFF_FFFC);

        // 1: streaming, first-instruction latency, in-order PCs
        do_reset();
        gcyc = -1;
        vcyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gcyc < 0 && imem_req && imem_gnt) gcyc = i;
            if (vcyc < 0 && id_valid) vcyc = i;
        end
        check_eq("t1_latency", 64'(vcyc - gcyc), 64'd2);
        wait_got(4, "t1_count");
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_pc",    got_pc[i],           64'(4 * i));
            check_eq("t1_instr", 64'(got_instr[i]),   64'(4 * i));
        end

        // 6a: PC wraps past 2^64 (second instance, same reset)
        check_eq("t6_pc0",    got2_pc[0],           64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("t6_instr0", 64'(got2_instr[0]),   64'hFFFF_FFFC);
        check_eq("t6_pc1",    got2_pc[1],           64'h0);
        check_eq("t6_instr1", 64'(got2_instr[1]),   64'h0);

        // 2: decode back-pressure
        id_ready = 1'b0;
        do_reset();
        repeat (6) begin
            @(negedge clk);
            #1;
        end
        check_eq("t2_req_drop", 64'(imem_req), 64'd0);
        check_eq("t2_grants",   64'(n_grants), 64'd2);
        check_eq("t2_valid",    64'(id_valid), 64'd1);
        check_eq("t2_pc_held",  id_pc,         64'h0);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        wait_got(3, "t2_count");
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_pc", got_pc[i], 64'(4 * i));
        end

        // 3: redirect with two fetches (0x8, 0xC) outstanding
        lat = 5;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8;
        @(negedge clk);
        check_eq("t3_req_in_redir0", 64'(imem_req), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        k = 0;
        while (n_grants < 2 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("t3_two_grants", 64'(n_grants), 64'd2);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1000;
        @(negedge clk);
        check_eq("t3_req_in_redir", 64'(imem_req), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        check_eq("t3_addr_next", imem_addr, 64'h1000);
        wait_got(1, "t3_count");
        check_eq("t3_first_pc",    got_pc[0],           64'h1000);
        check_eq("t3_first_instr", 64'(got_instr[0]),   64'h1000);

        // 4: redirect coincident with rvalid and id pop; target low bits cleared
        do_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        @(negedge clk);
        check_eq("t4_pre_valid",  64'(id_valid),    64'd1);
        check_eq("t4_pre_rvalid", 64'(imem_rvalid), 64'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_flush_valid", 64'(id_valid), 64'd0);
        wait_got(3, "t4_count");
        check_eq("t4_pc0",    got_pc[0],           64'h0);
        check_eq("t4_pc1",    got_pc[1],           64'h2000);
        check_eq("t4_instr1", 64'(got_instr[1]),   64'h2000);
        check_eq("t4_pc2",    got_pc[2],           64'h2004);

        // 5: grant withheld for three cycles
        imem_gnt = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_req_held",  64'(imem_req), 64'd1);
            check_eq("t5_addr_held", imem_addr,     64'h0);
        end
        @(posedge clk);
        #1;
        imem_gnt = 1'b1;
        wait_got(3, "t5_count");
        for (int i = 0; i < 3; i++) begin
            check_eq("t5_pc", got_pc[i], 64'(4 * i));
        end

        // 6b: asynchronous reset mid-stream
        do_reset();
        wait_got(2, "t6b_pre");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6b_valid", 64'(id_valid), 64'd0);
        check_eq("t6b_req",   64'(imem_req), 64'd0);
        check_eq("t6b_addr",  imem_addr,     64'h0);
        do_reset();
        wait_got(2, "t6b_count");
        check_eq("t6b_pc0", got_pc[0], 64'h0);
        check_eq("t6b_pc1", got_pc[1], 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
